// File: rtl/ahb_wrr_slave_arbiter.sv
// ahb_wrr_slave_arbiter
// Weighted round-robin arbiter for one AHB slave port. The grant is held for a
// whole burst. Each master may win up to max(weight,1) consecutive
// transactions before the search pointer moves past it.
// hburst carries the 3-bit AHB HBURST encoding (hburst_type).
// Optional build macro: ARB_TIMEOUT_EN. When it is defined, an undefined-length
// INCR burst is cut off after TIMEOUT_CYCLES accepted beats.
//
// state | meaning
// IDLE  | nobody owns the port, waiting for any request
// OWN   | grant_q owns the port, beats counted until the last one
module ahb_wrr_slave_arbiter #(
  parameter int SLAVE_X_MASTER_NUM = 4,
  parameter int WEIGHT_BIT         = 3,
  parameter int TIMEOUT_CYCLES     = 16
) (
  input  logic                                          hclk,
  input  logic                                          hreset_n,
  input  logic [SLAVE_X_MASTER_NUM-1:0]                 hreq,
  input  logic [2:0]                                    hburst,
  input  logic                                          hwait,
  input  logic [SLAVE_X_MASTER_NUM-1:0][WEIGHT_BIT-1:0] hweight,
  output logic [SLAVE_X_MASTER_NUM-1:0]                 hgrant,
  output logic                                          hsel,
  output logic [$clog2(SLAVE_X_MASTER_NUM)-1:0]         hmaster
);

  localparam int N  = SLAVE_X_MASTER_NUM;
  localparam int IW = $clog2(SLAVE_X_MASTER_NUM);
  localparam int W  = WEIGHT_BIT;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;
  localparam logic [2:0] BURST_INCR16 = 3'b111;

  if (SLAVE_X_MASTER_NUM < 2 || SLAVE_X_MASTER_NUM > 16 || WEIGHT_BIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ahb_wrr_slave_arbiter: parameter out of range");
  end

  logic [0:0]          state_q, state_d;
  logic [N-1:0]        grant_q, grant_d;
  logic [IW-1:0]       master_q, master_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [N-1:0][W-1:0] credit_q, credit_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          limit_q, limit_d;
  logic                incr_q, incr_d;
  logic                first_q, first_d;

  logic [N-1:0][W-1:0] reload;
  logic [N-1:0][W-1:0] credit_eff;
  logic [IW-1:0]       ptr_eff;
  logic [N-1:0]        ok, cand;
  logic [IW:0]         win;
  logic [3:0]          burst_limit, cur_limit;
  logic                burst_incr, cur_incr;
  logic                timeout_hit, last_beat, arb_en;

  // First candidate at or after start (wrapping); MSB flags a hit.
  function automatic logic [IW:0] pick(input logic [N-1:0] c, input logic [IW-1:0] start);
    logic [IW:0]   r;
    logic [IW-1:0] ix;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      ix = IW'((int'(start) + i) % N);
      if (c[ix]) r = {1'b1, ix};
    end
    return r;
  endfunction

  // Reload values: a zero weight still grants one transaction.
  always_comb begin
    for (int i = 0; i < N; i++) reload[i] = (hweight[i] == '0) ? W'(1) : hweight[i];
  end

  // Decode the owner's burst into the index of its last beat.
  always_comb begin
    burst_limit = 4'd0;
    case (hburst)
      BURST_WRAP4,  BURST_INCR4:  burst_limit = 4'd3;
      BURST_WRAP8,  BURST_INCR8:  burst_limit = 4'd7;
      BURST_WRAP16, BURST_INCR16: burst_limit = 4'd15;
      BURST_SINGLE, BURST_INCR:   burst_limit = 4'd0;
      default:                    burst_limit = 4'd0;
    endcase
  end

  assign burst_incr = (hburst == BURST_INCR);
  // The first owned cycle can already be the last beat, so use hburst directly.
  assign cur_limit  = first_q ? burst_limit : limit_q;
  assign cur_incr   = first_q ? burst_incr : incr_q;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
  assign timeout_hit = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign last_beat = (state_q == ST_OWN) && !hwait &&
                     (cur_incr ? (!hreq[master_q] || timeout_hit) : (cnt_q == cur_limit));

  // Next-state: beat counting, credit accounting and same-cycle re-arbitration.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    master_d   = master_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    limit_d    = limit_q;
    incr_d     = incr_q;
    first_d    = first_q;
    credit_eff = credit_q;
    ptr_eff    = ptr_q;
    arb_en     = 1'b0;
    ok         = '0;
    cand       = '0;
    win        = '0;
`ifdef ARB_TIMEOUT_EN
    to_d       = to_q;
`endif
    case (state_q)
      ST_IDLE: arb_en = |hreq;
      default: begin
        first_d = 1'b0;
        if (first_q) begin
          limit_d = burst_limit;
          incr_d  = burst_incr;
        end
        if (!hwait) begin
          cnt_d = cnt_q + 4'd1;
`ifdef ARB_TIMEOUT_EN
          to_d  = to_q + TO_W'(1);
`endif
        end
        if (last_beat) begin
          if (cur_incr && timeout_hit) credit_eff[master_q] = '0;
          else                         credit_eff[master_q] = credit_q[master_q] - W'(1);
          if (credit_eff[master_q] == '0)
            ptr_eff = (master_q == IW'(N - 1)) ? '0 : master_q + IW'(1);
          else
            ptr_eff = master_q;
          ptr_d  = ptr_eff;
          arb_en = 1'b1;
        end
      end
    endcase

    credit_d = credit_eff;
    if (arb_en) begin
      for (int i = 0; i < N; i++) ok[i] = hreq[i] && (credit_eff[i] != '0);
      cand = ok;
      // No eligible requester: every master gets a fresh quota this cycle.
      if (ok == '0 && hreq != '0) begin
        credit_d = reload;
        cand     = hreq;
      end
      win = pick(cand, ptr_eff);
      if (win[IW]) begin
        state_d  = ST_OWN;
        grant_d  = '0;
        grant_d[win[IW-1:0]] = 1'b1;
        master_d = win[IW-1:0];
        cnt_d    = '0;
        first_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
        to_d     = '0;
`endif
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      master_q <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      cnt_q    <= '0;
      limit_q  <= '0;
      incr_q   <= 1'b0;
      first_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      limit_q  <= limit_d;
      incr_q   <= incr_d;
      first_q  <= first_d;
`ifdef ARB_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  assign hgrant  = grant_q & {N{~hwait}};
  assign hsel    = |grant_q;
  assign hmaster = master_q;

endmodule

// File: tb/tb_ahb_wrr_slave_arbiter.sv
// Scoreboard bench for ahb_wrr_slave_arbiter: the stimulus side queues the
// hand-computed {hsel, hgrant, hmaster} for each cycle, the monitor pops and
// compares on the falling edge.
module tb_ahb_wrr_slave_arbiter;

  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_INCR16 = 3'd7;

  logic            hclk;
  logic            hreset_n;
  logic [3:0]      hreq;
  logic [2:0]      hburst;
  logic            hwait;
  logic [3:0][2:0] hweight;
  logic [3:0]      hgrant;
  logic            hsel;
  logic [1:0]      hmaster;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];
  string      tag_q[$];

  ahb_wrr_slave_arbiter #(
    .SLAVE_X_MASTER_NUM(4),
    .WEIGHT_BIT(3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .hclk(hclk),
    .hreset_n(hreset_n),
    .hreq(hreq),
    .hburst(hburst),
    .hwait(hwait),
    .hweight(hweight),
    .hgrant(hgrant),
    .hsel(hsel),
    .hmaster(hmaster)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic logic [6:0] ex(input logic s, input logic [3:0] g, input logic [1:0] m);
    return {s, g, m};
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue the outputs expected in it.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic [2:0] burst,
                     input logic wt, input logic [6:0] e, input string tag);
    @(posedge hclk);
    #1;
    hreset_n = rst;
    hreq     = req;
    hburst   = burst;
    hwait    = wt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic monitor();
    logic [6:0] e;
    string      t;
    forever begin
      @(negedge hclk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        if ({hsel, hgrant, hmaster} !== e) begin
          bad++;
          $display("FAIL %s: got sel=%b grant=%b master=%0d, want sel=%b grant=%b master=%0d",
                   t, hsel, hgrant, hmaster, e[6], e[5:2], e[1:0]);
        end
      end
    end
  endtask

  task automatic do_reset();
    cyc(1'b0, 4'b0000, B_SINGLE, 1'b0, ex(0, 4'b0000, 0), "reset");
  endtask

  initial begin
    hreset_n = 1'b0;
    hreq     = '0;
    hburst   = B_SINGLE;
    hwait    = 1'b0;
    for (int i = 0; i < 4; i++) hweight[i] = 3'd1;
    fork
      monitor();
    join_none

    // single master, single transfer, then request dropped
    do_reset();
    cyc(1, 4'b0001, B_SINGLE, 0, ex(0, 4'b0000, 0), "s1_idle");
    cyc(1, 4'b0000, B_SINGLE, 0, ex(1, 4'b0001, 0), "s1_grant");
    cyc(1, 4'b0000, B_SINGLE, 0, ex(0, 4'b0000, 0), "s1_release");

    // all four requesting, weights 1: 0,1,2,3,0 back to back
    do_reset();
    cyc(1, 4'b1111, B_SINGLE, 0, ex(0, 4'b0000, 0), "rr_idle");
    cyc(1, 4'b1111, B_SINGLE, 0, ex(1, 4'b0001, 0), "rr_m0");
    cyc(1, 4'b1111, B_SINGLE, 0, ex(1, 4'b0010, 1), "rr_m1");
    cyc(1, 4'b1111, B_SINGLE, 0, ex(1, 4'b0100, 2), "rr_m2");
    cyc(1, 4'b1111, B_SINGLE, 0, ex(1, 4'b1000, 3), "rr_m3");
    cyc(1, 4'b0000, B_SINGLE, 0, ex(1, 4'b0001, 0), "rr_m0_again");
    cyc(1, 4'b0000, B_SINGLE, 0, ex(0, 4'b0000, 0), "rr_release");

    // weight0=3, weight1=0 (counts as 1): 0,0,0,1,0,0,0,1
    hweight[0] = 3'd3;
    hweight[1] = 3'd0;
    do_reset();
    cyc(1, 4'b0011, B_SINGLE, 0, ex(0, 4'b0000, 0), "wrr_idle");
    cyc(1, 4'b0011, B_SINGLE, 0, ex(1, 4'b0001, 0), "wrr_a0");
    cyc(1, 4'b0011, B_SINGLE, 0, ex(1, 4'b0001, 0), "wrr_a1");
    cyc(1, 4'b0011, B_SINGLE, 0, ex(1, 4'b0001, 0), "wrr_a2");
    cyc(1, 4'b0011, B_SINGLE, 0, ex(1, 4'b0010, 1), "wrr_a3");
    cyc(1, 4'b0011, B_SINGLE, 0, ex(1, 4'b0001, 0), "wrr_b0");
    cyc(1, 4'b0011, B_SINGLE, 0, ex(1, 4'b0001, 0), "wrr_b1");
    cyc(1, 4'b0011, B_SINGLE, 0, ex(1, 4'b0001, 0), "wrr_b2");
    cyc(1, 4'b0000, B_SINGLE, 0, ex(1, 4'b0010, 1), "wrr_b3");
    cyc(1, 4'b0000, B_SINGLE, 0, ex(0, 4'b0000, 1), "wrr_release");
    hweight[0] = 3'd1;
    hweight[1] = 3'd1;

    // master 2 INCR8 with waits on beats 3 and 7; master 0 waiting
    do_reset();
    cyc(1, 4'b0100, B_INCR8, 0, ex(0, 4'b0000, 0), "b8_idle");
    cyc(1, 4'b0101, B_INCR8, 0, ex(1, 4'b0100, 2), "b8_beat0");
    cyc(1, 4'b0101, B_INCR8, 0, ex(1, 4'b0100, 2), "b8_beat1");
    cyc(1, 4'b0101, B_INCR8, 0, ex(1, 4'b0100, 2), "b8_beat2");
    cyc(1, 4'b0101, B_INCR8, 1, ex(1, 4'b0000, 2), "b8_beat3_wait");
    cyc(1, 4'b0101, B_INCR8, 0, ex(1, 4'b0100, 2), "b8_beat3");
    cyc(1, 4'b0101, B_INCR8, 0, ex(1, 4'b0100, 2), "b8_beat4");
    cyc(1, 4'b0101, B_INCR8, 0, ex(1, 4'b0100, 2), "b8_beat5");
    cyc(1, 4'b0101, B_INCR8, 0, ex(1, 4'b0100, 2), "b8_beat6");
    cyc(1, 4'b0101, B_INCR8, 1, ex(1, 4'b0000, 2), "b8_beat7_wait");
    cyc(1, 4'b0101, B_INCR8, 0, ex(1, 4'b0100, 2), "b8_beat7");
    cyc(1, 4'b0000, B_SINGLE, 0, ex(1, 4'b0001, 0), "b8_switch_m0");
    cyc(1, 4'b0000, B_SINGLE, 0, ex(0, 4'b0000, 0), "b8_release");

    // asynchronous reset in the middle of an INCR16 owned by master 1
    do_reset();
    cyc(1, 4'b0010, B_INCR16, 0, ex(0, 4'b0000, 0), "r16_idle");
    cyc(1, 4'b0010, B_INCR16, 0, ex(1, 4'b0010, 1), "r16_beat0");
    cyc(1, 4'b0010, B_INCR16, 0, ex(1, 4'b0010, 1), "r16_beat1");
    cyc(0, 4'b0010, B_INCR16, 0, ex(0, 4'b0000, 0), "r16_async_reset");
    cyc(1, 4'b1000, B_SINGLE, 0, ex(0, 4'b0000, 0), "r16_after_idle");
    cyc(1, 4'b0000, B_SINGLE, 0, ex(1, 4'b1000, 3), "r16_m3_grant");
    cyc(1, 4'b0000, B_SINGLE, 0, ex(0, 4'b0000, 3), "r16_release");

    // master 0 INCR held with master 1 waiting
    do_reset();
    cyc(1, 4'b0001, B_INCR, 0, ex(0, 4'b0000, 0), "to_idle");
    for (int k = 1; k <= 16; k++)
      cyc(1, 4'b0011, B_INCR, 0, ex(1, 4'b0001, 0), "to_m0_hold");
`ifdef ARB_TIMEOUT_EN
    cyc(1, 4'b0000, B_INCR, 0, ex(1, 4'b0010, 1), "to_m1_after_timeout");
    cyc(1, 4'b0000, B_INCR, 0, ex(0, 4'b0000, 1), "to_release");
`else
    cyc(1, 4'b0000, B_INCR, 0, ex(1, 4'b0001, 0), "to_m0_keeps");
    cyc(1, 4'b0000, B_INCR, 0, ex(0, 4'b0000, 0), "to_release");
`endif

    // let the monitor drain the queue, bounded
    for (int n = 0; n < 6 && exp_q.size() != 0; n++) @(negedge hclk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_wrr_slave_arbiter.md
Name: ahb_wrr_slave_arbiter

Overview:
Weighted round-robin arbiter for one AHB slave port. It shares the slave between SLAVE_X_MASTER_NUM masters and holds the grant for a full burst. Each master gets a programmable number of consecutive transactions (credits) before the grant pointer moves on. It is the drop-in alternative to the per-slave priority arbiters when fairness with bandwidth weighting is required.

Parameters:
SLAVE_X_MASTER_NUM, 4, number of requesting masters (2..16)
WEIGHT_BIT, 3, width of each per-master weight field
TIMEOUT_CYCLES, 16, maximum beats held for an undefined-length INCR burst (used only with ARB_TIMEOUT_EN)

Ports:
hclk  input  1  clock
hreset_n  input  1  asynchronous active-low reset
hreq  input  SLAVE_X_MASTER_NUM  per-master request
hburst  input  hburst_type (AHB_package)  burst type of the current owner's transfer
hwait  input  1  slave wait; 1 = current beat not accepted
hweight  input  [SLAVE_X_MASTER_NUM][WEIGHT_BIT]  per-master weight; quasi-static; 0 treated as 1
hgrant  output  SLAVE_X_MASTER_NUM  one-hot grant, registered grant masked by ~hwait
hsel  output  1  1 when any master owns the port (|grant, unmasked)
hmaster  output  $clog2(SLAVE_X_MASTER_NUM)  index of the owning master; holds its last value when idle

Behaviour:
- Reset: grant=0, hgrant=0, hsel=0, hmaster=0, state=IDLE, pointer=0, all credits=0, beat count=0. Reset is asynchronous and takes effect immediately, including mid-burst.
- States: IDLE, OWN.
- Arbitration, combinational:
  - Search starts at pointer and wraps, modulo SLAVE_X_MASTER_NUM.
  - The winner is the first requesting master with credit>0.
  - If no requesting master has credit>0, all credits reload to max(weight,1) and the search repeats in the same cycle.
- IDLE: if |hreq, the winner is registered into grant. The state goes to OWN and hsel rises the next cycle, so request-to-grant latency is 1 cycle.
- OWN, first cycle: hburst is sampled into the burst register and limit is set:
  - WRAP4/INCR4 = 3
  - WRAP8/INCR8 = 7
  - WRAP16/INCR16 = 15
  - SINGLE = 0
  - INCR = undefined length
- OWN, beat counting: the 4-bit count increments only on cycles with hwait=0.
- Last beat:
  - Fixed burst: count==limit and hwait=0.
  - INCR: owner hreq=0 and hwait=0.
  - An owner dropping hreq during a fixed burst is ignored.
- On the last beat:
  - Owner credit decrements by 1.
  - If the credit becomes 0, pointer = owner+1 (wrapping); otherwise pointer = owner.
  - Arbitration runs in the same cycle. If it has a winner, grant switches directly with no idle cycle and the state stays OWN with count cleared. If not, grant=0 and the state goes to IDLE.
- hwait=1 on the last beat: everything holds until hwait=0.
- Single requester: keeps re-winning, reloading credits as needed. Back-to-back transactions have no idle gap.
- Owner with credit>0 still requesting at the last beat: re-wins (weighting).
- hmaster is updated in the same cycle as grant.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: an INCR burst is force-terminated after TIMEOUT_CYCLES accepted beats. Termination is a normal last beat: credit decrement and re-arbitration. The owner's credit is set to 0 so the pointer advances.
- Not defined: INCR bursts are held indefinitely while the owner requests, and TIMEOUT_CYCLES is unused.

Test Plan:
- Reset, then hreq=4'b0001, SINGLE, weights=1 → hsel=1 and hgrant=4'b0001 one cycle later; hgrant=0 after the beat with hreq dropped.
- hreq=4'b1111, all weights=1, SINGLE, hwait=0 → grant order 0,1,2,3,0, one master per cycle with no gaps.
- hreq=4'b0011, weight0=3, weight1=1, SINGLE → repeating grant pattern 0,0,0,1.
- Master 2 INCR8 with hwait=1 on beats 3 and 7 → grant held 10 cycles; switch occurs only on the cycle after beat 7 is accepted.
- Assert hreset_n=0 mid-INCR16 → hgrant, hsel and hmaster are 0 immediately. After release, hreq=4'b1000 is granted to master 3, because the pointer is 0 and credits reload.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: master 0 INCR held continuously, master 1 requesting → master 1 granted right after beat 16 of master 0. Without the macro, master 0 keeps the grant.
